// File: rtl/jk_seq_monitor.sv
// jk_seq_monitor: checks a 4-bit JK counter against its period-7 code cycle
// 0000->0001->0011->0101->0111->1011->1101->0000. It tracks the position in
// the cycle, counts completed periods, and flags, counts and latches faults.
module jk_seq_monitor #(
    parameter int ERR_W = 8,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       code_in,
    input  logic             clr_err,
    output logic             in_sync,
    output logic [2:0]       seq_idx,
    output logic [3:0]       code_q,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [PER_W-1:0] period_cnt
);

    typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

    state_t           state, state_n;
    logic [2:0]       idx_n;
    logic [3:0]       code_n;
    logic             pulse_n;
    logic             sticky_n;
    logic [ERR_W-1:0] err_n;
    logic [PER_W-1:0] per_n;
    logic             fault;

    // Code expected after the code at position idx; position 6 closes the period.
    function automatic logic [3:0] successor(input logic [2:0] idx);
        case (idx)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0011;
            3'd2:    return 4'b0101;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b1011;
            3'd5:    return 4'b1101;
            default: return 4'b0000;
        endcase
    endfunction

    // Next sequence position, wrapping 6 back to 0.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= 3'd6) ? 3'd0 : idx + 3'd1;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // The state register doubles as the registered in_sync flag.
    assign in_sync = (state == TRACK);

    // Next-state, sequence tracking and error bookkeeping.
    always_comb begin
        state_n  = state;
        idx_n    = seq_idx;
        code_n   = code_q;
        pulse_n  = 1'b0;
        sticky_n = err_sticky;
        err_n    = err_cnt;
        per_n    = period_cnt;
        fault    = 1'b0;

        if (en) begin
            code_n = code_in;
            case (state)
                SYNC: begin
                    // Out-of-sync codes are ignored until the cycle start shows up.
                    if (code_in == 4'b0000) begin
                        state_n = TRACK;
                        idx_n   = 3'd0;
                    end
                end
                TRACK: begin
                    if (code_in == successor(seq_idx)) begin
                        idx_n = next_idx(seq_idx);
                        if (seq_idx == 3'd6)
                            per_n = period_cnt + PER_W'(1);
                    end else begin
                        fault = 1'b1;
                        idx_n = 3'd0;
                        // A 0000 is itself a valid anchor, so relock without leaving TRACK.
                        if (code_in != 4'b0000)
                            state_n = SYNC;
                    end
                end
                default: state_n = SYNC;
            endcase
        end

        // A fault on the same edge as a clear starts the count fresh at 1.
        if (fault) begin
            pulse_n  = 1'b1;
            sticky_n = 1'b1;
            err_n    = clr_err ? ERR_W'(1) : sat_inc(err_cnt);
        end else if (clr_err) begin
            sticky_n = 1'b0;
            err_n    = '0;
        end
    end

    // All outputs registered; asynchronous reset returns everything to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            seq_idx    <= 3'd0;
            code_q     <= 4'b0000;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            period_cnt <= '0;
        end else begin
            state      <= state_n;
            seq_idx    <= idx_n;
            code_q     <= code_n;
            err_pulse  <= pulse_n;
            err_sticky <= sticky_n;
            err_cnt    <= err_n;
            period_cnt <= per_n;
        end
    end

endmodule
